// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// BREAK/MAB states are only reachable when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_MAB
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  localparam int DIV_MIN = 2;

  function automatic logic par_bit(
    input logic [1:0] mode,
    input logic       x
  );
    return (mode == PAR_EVEN) ? x  :
           (mode == PAR_ODD)  ? ~x : 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side bundle of the UART transmitter: payload, config, line.
// tx_break exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) ();
  import uart_pkg::*;

  localparam int LEN_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DIV_W-1:0]  cfg_div;
  logic [LEN_W-1:0]  cfg_len;
  logic [1:0]        cfg_par;
  logic              cfg_stop2;
  logic              uart_txd;
  logic              tx_busy;
  logic              tx_done;

`ifdef UART_TX_BREAK_EN
  logic              tx_break;

  modport master (
    output tx_data, tx_valid, cfg_div, cfg_len,
    output cfg_par, cfg_stop2, tx_break,
    input  tx_ready, uart_txd, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid, cfg_div, cfg_len,
    input  cfg_par, cfg_stop2, tx_break,
    output tx_ready, uart_txd, tx_busy, tx_done
  );
`else
  modport master (
    output tx_data, tx_valid, cfg_div, cfg_len,
    output cfg_par, cfg_stop2,
    input  tx_ready, uart_txd, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid, cfg_div, cfg_len,
    input  cfg_par, cfg_stop2,
    output tx_ready, uart_txd, tx_busy, tx_done
  );
`endif

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period cycle counter with clear and a bit_end strobe.
// Shared with the receiver; counts 0..i_div-1 while enabled.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == i_div - DIV_W'(1));
  assign o_bit_end = i_en && w_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (len/parity/stop/divisor per frame).
// Define UART_TX_BREAK_EN to add the tx_break line-break generator.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input logic          clk,
  input logic          resetn,
  uart_tx_cfg_if.slave bus
);

  localparam int LEN_W = $clog2(DATA_W + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] w_sh_nxt;
  logic [LEN_W-1:0]  r_bcnt;
  logic [LEN_W-1:0]  w_bcnt_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_eff;
  logic [1:0]        r_par_mode;
  logic              r_par_bit;
  logic              r_stop2;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_eff;
  logic [DATA_W-1:0] w_mask;
  logic              w_par_new;
  logic              r_txd;
  logic              w_txd_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              w_clr;
  logic              w_en;
  logic              w_bit_end;

  assign w_div_eff =
    (bus.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.cfg_div;

  assign w_len_eff =
    (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(DATA_W)) ?
    LEN_W'(DATA_W) : bus.cfg_len;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_mask[i] = (i < int'(w_len_eff));
    end
  end

  assign w_par_new = par_bit(bus.cfg_par, ^(bus.tx_data & w_mask));

`ifdef UART_TX_BREAK_EN
  assign w_ready = (r_state == S_IDLE) && !bus.tx_break;
`else
  assign w_ready = (r_state == S_IDLE);
`endif

  assign w_accept = bus.tx_valid && w_ready;
  assign w_en     = !(r_state inside {S_IDLE, S_BREAK});

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk       (clk),
    .resetn    (resetn),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_div     (r_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_txd_nxt   = r_txd;
    w_sh_nxt    = r_sh;
    w_bcnt_nxt  = r_bcnt;
    w_done_nxt  = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_sh_nxt    = bus.tx_data;
          w_bcnt_nxt  = '0;
          w_clr       = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        else if (bus.tx_break) begin
          w_state_nxt = S_BREAK;
          w_txd_nxt   = 1'b0;
        end
`endif
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_sh[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bcnt == r_len - LEN_W'(1)) begin
            w_bcnt_nxt = '0;
            if (r_par_mode != PAR_NONE) begin
              w_state_nxt = S_PARITY;
              w_txd_nxt   = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_sh_nxt   = r_sh >> 1;
            w_txd_nxt  = r_sh[1];
            w_bcnt_nxt = r_bcnt + LEN_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && r_bcnt == '0) begin
            w_bcnt_nxt = LEN_W'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_bcnt_nxt  = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!bus.tx_break) begin
          w_state_nxt = S_MAB;
          w_txd_nxt   = 1'b1;
          w_clr       = 1'b1;
        end
      end
      S_MAB: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // Frame config is sampled only on accept; divisor also on MAB entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
      r_sh       <= '0;
      r_bcnt     <= '0;
      r_len      <= '0;
      r_par_mode <= PAR_NONE;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_div      <= '0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_done <= w_done_nxt;
      r_sh   <= w_sh_nxt;
      r_bcnt <= w_bcnt_nxt;
      if (w_accept) begin
        r_len      <= w_len_eff;
        r_par_mode <= bus.cfg_par;
        r_par_bit  <= w_par_new;
        r_stop2    <= bus.cfg_stop2;
      end
      if (w_clr) begin
        r_div <= w_div_eff;
      end
    end
  end

  assign bus.tx_ready = w_ready;
  assign bus.tx_busy  = !w_ready;
  assign bus.uart_txd = r_txd;
  assign bus.tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg with a per-cycle line model.
// Define UART_TX_BREAK_EN to also exercise the break generator.
module tb_uart_tx_cfg;

  localparam int LOGN = 32768;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic brk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_tx_cfg_if #(.DATA_W(8), .DIV_W(16)) bus ();

`ifdef UART_TX_BREAK_EN
  assign bus.tx_break = brk;
`endif

  uart_tx_cfg #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Model: queue of future line cycles, {last_of_frame, level}
  logic [1:0] mq[$];
  logic e_txd, e_busy, e_brk, e_done, pend;
  logic exp_rdy, go_brk;
  logic line_log[LOGN];
  logic rdy_log[LOGN];

  function automatic void model_reset();
    mq.delete();
    e_txd  = 1'b1;
    e_busy = 1'b0;
    e_brk  = 1'b0;
    e_done = 1'b0;
    pend   = 1'b0;
  endfunction

  function automatic void push_frame(input logic [7:0] d, input int dv,
                                     input int ln, input int pr, input int s2);
    logic b[$];
    int   ones = 0;
    int   de = (dv < 2) ? 2 : dv;
    int   le = (ln == 0 || ln > 8) ? 8 : ln;
    b.push_back(1'b0);
    for (int i = 0; i < le; i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pr == 1) b.push_back(ones % 2 == 1);
    else if (pr == 2) b.push_back(ones % 2 == 0);
    else if (pr == 3) b.push_back(1'b1);
    b.push_back(1'b1);
    if (s2 != 0) b.push_back(1'b1);
    foreach (b[k]) begin
      for (int c = 0; c < de; c++) begin
        mq.push_back({(k == b.size() - 1) && (c == de - 1), b[k]});
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      model_reset();
    end else begin
      exp_rdy = !e_busy && !brk;
      chk("txd", int'(bus.uart_txd), int'(e_txd));
      chk("ready", int'(bus.tx_ready), int'(exp_rdy));
      chk("busy", int'(bus.tx_busy), int'(!exp_rdy));
      chk("done", int'(bus.tx_done), int'(e_done));
      go_brk = brk && (!e_busy || e_brk);
      if (exp_rdy && bus.tx_valid)
        push_frame(bus.tx_data, int'(bus.cfg_div), int'(bus.cfg_len),
                   int'(bus.cfg_par), int'(bus.cfg_stop2));
      if (e_brk && !brk) begin
        for (int c = 0; c < ((bus.cfg_div < 2) ? 2 : int'(bus.cfg_div)); c++)
          mq.push_back(2'b01);
      end
      if (mq.size() > 0) begin
        logic [1:0] v;
        v = mq.pop_front();
        e_txd = v[0]; e_busy = 1'b1; e_brk = 1'b0;
        e_done = 1'b0; pend = v[1];
      end else if (go_brk) begin
        e_txd = 1'b0; e_busy = 1'b1; e_brk = 1'b1; e_done = 1'b0;
      end else begin
        e_txd = 1'b1; e_busy = 1'b0; e_brk = 1'b0;
        e_done = pend; pend = 1'b0;
      end
    end
    if (cyc < LOGN) begin
      line_log[cyc] = bus.uart_txd;
      rdy_log[cyc]  = bus.tx_ready;
    end
  end

  task automatic set_cfg(input logic [7:0] d, input int dv, input int ln,
                         input int pr, input int s2);
    bus.tx_data   = d;
    bus.cfg_div   = 16'(dv);
    bus.cfg_len   = 4'(ln);
    bus.cfg_par   = 2'(pr);
    bus.cfg_stop2 = 1'(s2);
  endtask

  task automatic send(input logic [7:0] d, input int dv, input int ln,
                      input int pr, input int s2, output int acc);
    bit ok = 0;
    acc = -1;
    @(posedge clk); #1;
    set_cfg(d, dv, ln, pr, s2);
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        bus.tx_valid = 1'b0;
        ok = 1;
      end
    end
    if (!ok) begin
      bus.tx_valid = 1'b0;
      chk("send_timeout", 0, 1);
    end
  endtask

  task automatic wait_done(output int dc);
    bit got = 0;
    dc = -1;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        got = 1;
        dc = cyc;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int a, a2, dc, n;
    int acc2[2];
    logic [9:0] pat;
    bus.tx_valid = 1'b0;
    set_cfg(8'h00, 4, 8, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", int'(bus.uart_txd), 1);
    chk("rst_ready", int'(bus.tx_ready), 1);
    chk("rst_busy", int'(bus.tx_busy), 0);
    chk("rst_done", int'(bus.tx_done), 0);
    #2 resetn = 1'b1;

    // 0xA5, div 4, 8N1
    send(8'hA5, 4, 8, 0, 0, a);
    wait_done(dc);
    chk("a5_len", dc - a, 40);
    pat = 10'b11_0100_1010;
    for (int k = 0; k < 10; k++)
      chk("a5_bit", int'(line_log[a + 4 * k + 2]), int'(pat[k]));

    // len 7 with parity; bit 7 excluded
    send(8'hFF, 4, 7, 1, 0, a);
    wait_done(dc);
    chk("even_len", dc - a, 40);
    chk("even_b6", int'(line_log[a + 4 * 7 + 2]), 1);
    chk("even_par", int'(line_log[a + 4 * 8 + 2]), 1);
    send(8'h03, 4, 7, 2, 0, a);
    wait_done(dc);
    chk("odd_b2", int'(line_log[a + 4 * 3 + 2]), 0);
    chk("odd_par", int'(line_log[a + 4 * 8 + 2]), 1);

    // two stop bits, valid held across two frames
    @(posedge clk); #1;
    set_cfg(8'h3C, 3, 8, 0, 1);
    bus.tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        @(posedge clk); #1;
        acc2[n] = cyc;
        n++;
      end
    end
    bus.tx_valid = 1'b0;
    chk("b2b_count", n, 2);
    wait_done(dc);
    if (n == 2) begin
      chk("b2b_period", acc2[1] - acc2[0], 34);
      chk("b2b_len", dc - acc2[1], 33);
      chk("b2b_stop2", int'(line_log[acc2[0] + 32]), 1);
      chk("b2b_idle", int'(line_log[acc2[0] + 33]), 1);
      chk("b2b_start", int'(line_log[acc2[0] + 34]), 0);
    end

    // divisor clamp and mid-frame divisor change
    send(8'h01, 0, 8, 0, 0, a);
    wait_done(dc);
    chk("div0_len", dc - a, 20);
    chk("div0_s1", int'(line_log[a + 1]), 0);
    chk("div0_b0", int'(line_log[a + 2]), 1);
    send(8'h55, 10, 8, 0, 0, a);
    repeat (30) @(posedge clk);
    #1 bus.cfg_div = 16'd5;
    wait_done(dc);
    chk("div10_len", dc - a, 100);
    send(8'h55, 5, 8, 0, 0, a);
    wait_done(dc);
    chk("div5_len", dc - a, 50);

    // reset in the middle of DATA
    send(8'h96, 8, 8, 0, 0, a);
    repeat (20) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("mrst_txd", int'(bus.uart_txd), 1);
    chk("mrst_ready", int'(bus.tx_ready), 1);
    chk("mrst_done", int'(bus.tx_done), 0);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    send(8'h5A, 3, 8, 0, 0, a);
    wait_done(dc);
    chk("post_rst_len", dc - a, 30);

`ifdef UART_TX_BREAK_EN
    @(posedge clk); #1;
    bus.cfg_div = 16'd8;
    brk = 1'b1;
    a2 = cyc;
    repeat (50) @(posedge clk);
    #1 brk = 1'b0;
    repeat (12) @(posedge clk);
    chk("brk_pre", int'(line_log[a2]), 1);
    chk("brk_low0", int'(line_log[a2 + 1]), 0);
    chk("brk_low49", int'(line_log[a2 + 50]), 0);
    chk("mab_hi", int'(line_log[a2 + 51]), 1);
    chk("mab_rdy", int'(rdy_log[a2 + 58]), 0);
    chk("mab_end", int'(rdy_log[a2 + 59]), 1);
`endif

    // random frames with mid-frame config noise
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(8'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 3), $urandom_range(0, 1), a);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1;
        set_cfg(8'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom_range(0, 1));
      end
    end
    wait_done(dc);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
